// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out stream serialiser.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Number of beats needed to emit one parallel word.
  function automatic int unsigned piso_beats(input int unsigned width,
                                             input int unsigned lanes);
    return width / lanes;
  endfunction

  // Beat counter width, never narrower than one bit.
  function automatic int unsigned piso_cw(input int unsigned beats);
    return (beats < 2) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-word holding buffer that lets the next word queue behind the one being shifted.
module piso_hold_reg
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             take_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] hbuf_q;
  logic             hvalid_q;

  // Load has priority; load and take never coincide because load needs an empty buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      hbuf_q   <= '0;
      hvalid_q <= 1'b0;
    end else if (load_i) begin
      hbuf_q   <= data_i;
      hvalid_q <= 1'b1;
    end else if (take_i) begin
      hvalid_q <= 1'b0;
    end
  end

  assign data_o  = hbuf_q;
  assign valid_o = hvalid_q;

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out serialiser with valid/ready on both sides and a one-word
// holding buffer so back-to-back words stream without idle beats.
module piso_stream
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out_data,
  output logic             out_first,
  output logic             out_last
);

  localparam int unsigned    BEATS    = piso_beats(WIDTH, LANES);
  localparam int unsigned    CW       = piso_cw(BEATS);
  localparam logic [CW-1:0]  LAST_CNT = CW'(BEATS - 1);

  // Reject illegal geometries at elaboration.
  if (WIDTH < 2) begin : g_bad_width
    $error("piso_stream: WIDTH must be at least 2");
  end
  if ((WIDTH % LANES) != 0) begin : g_bad_lanes
    $error("piso_stream: WIDTH must be a multiple of LANES");
  end

  piso_state_t      state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hbuf;
  logic             hvalid;
  logic             hold_load, hold_take;
  logic             acc, bt, last_bt;
  logic [WIDTH-1:0] sreg_sh;

  assign in_ready  = ~hvalid & ~rst;
  assign out_valid = (state_q == SHIFT);
  assign out_first = (cnt_q == '0);
  assign out_last  = (cnt_q == LAST_CNT);

  assign acc     = in_valid & in_ready;
  assign bt      = out_valid & out_ready;
  assign last_bt = bt & out_last;

  // Move the next beat to the output end, zero-filling behind it.
  assign sreg_sh = MSB_FIRST ? (sreg_q << LANES) : (sreg_q >> LANES);

  if (MSB_FIRST) begin : g_msb
    assign out_data = sreg_q[WIDTH-1 -: LANES];
  end else begin : g_lsb
    assign out_data = sreg_q[LANES-1:0];
  end

  piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load_i (hold_load),
    .take_i (hold_take),
    .data_i (in_data),
    .data_o (hbuf),
    .valid_o(hvalid)
  );

  // State, shift register and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: load a word, shift a beat, or chain the next word on the last beat.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    hold_load = 1'b0;
    hold_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          sreg_d  = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bt) begin
          if (hvalid) begin
            sreg_d    = hbuf;
            cnt_d     = '0;
            hold_take = 1'b1;
          end else if (acc) begin
            sreg_d = in_data;
            cnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (bt) begin
            sreg_d = sreg_sh;
            cnt_d  = cnt_q + CW'(1);
          end
          if (acc) begin
            hold_load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: an LSB-first 1-lane instance and an MSB-first 4-lane instance.
module tb_piso_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  iv, ordy;
  logic [15:0] id0, id1;
  wire  [1:0]  ir, ov, of, ol;
  wire  [0:0]  od0;
  wire  [3:0]  od1;

  piso_stream #(.WIDTH(16), .LANES(1), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id0),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0),
    .out_first(of[0]), .out_last(ol[0])
  );

  piso_stream #(.WIDTH(16), .LANES(4), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id1),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1),
    .out_first(of[1]), .out_last(ol[1])
  );

  typedef struct {
    int          sel;
    logic [15:0] d;
    logic [15:0] exp;   // beat k of the word sits at exp[k*lanes +: lanes]
  } vec_t;

  typedef struct {
    logic [3:0] v;
    int         k;
  } beat_t;

  int    n_chk  = 0;
  int    n_fail = 0;
  beat_t q0[$];
  beat_t q1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int beats_of(input int s);
    return (s == 0) ? 16 : 4;
  endfunction

  function automatic logic [3:0] dout(input int s);
    return (s == 0) ? {3'b000, od0} : od1;
  endfunction

  // Reference beat value straight from the word: bit k LSB-first, or nibble k from the top.
  function automatic logic [3:0] exp_beat(input int s, input logic [15:0] w, input int k);
    if (s == 0) return {3'b000, w[k]};
    return 4'((w >> (12 - 4 * k)) & 16'h000F);
  endfunction

  function automatic int qsize(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push_word(input int s, input logic [15:0] w);
    beat_t b;
    for (int k = 0; k < beats_of(s); k++) begin
      b.v = exp_beat(s, w, k);
      b.k = k;
      if (s == 0) q0.push_back(b);
      else        q1.push_back(b);
    end
  endtask

  // Compare one cycle of DUT s against the queued beat stream; called at negedge.
  task automatic model_cycle(input int s);
    beat_t b;
    int    sz;
    sz = qsize(s);
    chk("rnd_out_valid", 32'(ov[s]), 32'(sz != 0));
    chk("rnd_in_ready", 32'(ir[s]), 32'(sz <= beats_of(s)));
    if (ov[s] && ordy[s] && sz != 0) begin
      if (s == 0) b = q0.pop_front();
      else        b = q1.pop_front();
      chk("rnd_out_data", 32'(dout(s)), 32'(b.v));
      chk("rnd_out_first", 32'(of[s]), 32'(b.k == 0));
      chk("rnd_out_last", 32'(ol[s]), 32'(b.k == beats_of(s) - 1));
    end
    if (iv[s] && ir[s]) push_word(s, (s == 0) ? id0 : id1);
  endtask

  // Send one word with out_ready high and check every beat and the return to idle.
  task automatic run_word(input vec_t v);
    logic [3:0] e;
    ordy[v.sel] = 1'b1;
    if (v.sel == 0) id0 = v.d;
    else            id1 = v.d;
    iv[v.sel] = 1'b1;
    @(negedge clk);
    chk("vec_in_ready", 32'(ir[v.sel]), 32'd1);
    step();
    iv[v.sel] = 1'b0;
    for (int k = 0; k < beats_of(v.sel); k++) begin
      e = (v.sel == 0) ? {3'b000, v.exp[k]} : v.exp[4*k +: 4];
      @(negedge clk);
      chk("vec_out_valid", 32'(ov[v.sel]), 32'd1);
      chk("vec_out_data", 32'(dout(v.sel)), 32'(e));
      chk("vec_out_first", 32'(of[v.sel]), 32'(k == 0));
      chk("vec_out_last", 32'(ol[v.sel]), 32'(k == beats_of(v.sel) - 1));
      step();
    end
    @(negedge clk);
    chk("vec_idle_after", 32'(ov[v.sel]), 32'd0);
    step();
    ordy[v.sel] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[6];
    logic [15:0] w;
    int          k, stalls, vcnt, seen;

    vt[0] = '{0, 16'hA5C3, 16'hA5C3};
    vt[1] = '{0, 16'h0001, 16'h0001};
    vt[2] = '{0, 16'h8000, 16'h8000};
    vt[3] = '{1, 16'h1234, 16'h4321};
    vt[4] = '{1, 16'hBEEF, 16'hFEEB};
    vt[5] = '{1, 16'h0F5A, 16'hA5F0};

    rst = 1'b1; iv = '0; ordy = '0; id0 = '0; id1 = '0;
    step();
    step();

    // Reset state.
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_out_valid", 32'(ov[s]), 32'd0);
      chk("rst_out_data", 32'(dout(s)), 32'd0);
      chk("rst_out_first", 32'(of[s]), 32'd1);
      chk("rst_out_last", 32'(ol[s]), 32'd0);
      chk("rst_in_ready", 32'(ir[s]), 32'd0);
    end
    step();
    rst = 1'b0;

    // Idle with no input for 20 cycles.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_out_valid", 32'(ov), 32'd0);
      chk("idle_in_ready", 32'(ir), 32'd3);
      step();
    end

    // Single-word vectors.
    for (int i = 0; i < 6; i++) run_word(vt[i]);

    // Back-to-back 0xFFFF then 0x0000: 32 gapless beats.
    ordy[0] = 1'b1;
    id0 = 16'hFFFF;
    iv[0] = 1'b1;
    step();
    id0 = 16'h0000;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      chk("b2b_out_valid", 32'(ov[0]), 32'd1);
      chk("b2b_out_data", 32'(od0), 32'(j < 16));
      chk("b2b_in_ready", 32'(ir[0]), 32'(j == 0 || j >= 16));
      chk("b2b_out_first", 32'(of[0]), 32'(j % 16 == 0));
      chk("b2b_out_last", 32'(ol[0]), 32'(j % 16 == 15));
      step();
      if (j == 0) iv[0] = 1'b0;
    end
    @(negedge clk);
    chk("b2b_idle_after", 32'(ov[0]), 32'd0);
    step();

    // Back-pressure: 3 stalled cycles at beat 5.
    w = 16'hA5C3;
    id0 = w;
    iv[0] = 1'b1;
    ordy[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    k = 0; stalls = 0; vcnt = 0;
    for (int c = 0; c < 40 && k < 16; c++) begin
      ordy[0] = !(k == 5 && stalls < 3);
      @(negedge clk);
      if (ov[0]) vcnt++;
      chk("bp_out_valid", 32'(ov[0]), 32'd1);
      chk("bp_out_data", 32'(od0), 32'(w[k]));
      chk("bp_out_first", 32'(of[0]), 32'(k == 0));
      chk("bp_out_last", 32'(ol[0]), 32'(k == 15));
      if (!ordy[0]) stalls++;
      else          k++;
      step();
    end
    @(negedge clk);
    chk("bp_idle_after", 32'(ov[0]), 32'd0);
    chk("bp_valid_cycles", 32'(vcnt), 32'd19);
    chk("bp_beats_done", 32'(k), 32'd16);
    step();

    // Reset at beat 7 with the holding buffer full; nothing pending may come out.
    w = 16'h5A5A;
    id0 = w;
    iv[0] = 1'b1;
    ordy[0] = 1'b1;
    step();
    id0 = 16'hC3C3;
    step();
    iv[0] = 1'b0;
    for (int j = 1; j < 7; j++) step();
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_beat7_valid", 32'(ov[0]), 32'd1);
    chk("mrst_beat7_data", 32'(od0), 32'(w[7]));
    chk("mrst_in_ready_in_rst", 32'(ir[0]), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", 32'(ov[0]), 32'd0);
    chk("mrst_in_ready", 32'(ir[0]), 32'd1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      @(negedge clk);
      if (ov[0]) seen++;
    end
    chk("mrst_no_stale_beats", 32'(seen), 32'd0);
    step();

    // Randomised traffic on both instances against the beat-queue model.
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < 2; s++) begin
        iv[s]   = ($urandom_range(0, 3) != 0);
        ordy[s] = ($urandom_range(0, 9) < 7);
      end
      id0 = 16'($urandom);
      id1 = 16'($urandom);
      @(negedge clk);
      for (int s = 0; s < 2; s++) model_cycle(s);
      step();
    end

    // Drain whatever is still in flight.
    iv = '0;
    ordy = 2'b11;
    for (int c = 0; c < 200 && (q0.size() != 0 || q1.size() != 0); c++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) model_cycle(s);
      step();
    end
    @(negedge clk);
    chk("drain_q0_empty", 32'(q0.size()), 32'd0);
    chk("drain_q1_empty", 32'(q1.size()), 32'd0);
    chk("drain_out_valid", 32'(ov), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_stream.md
# piso_stream

Parametrised parallel-in/serial-out serialiser with valid/ready handshakes on both sides. It is the successor to the single-bit load/shift PISO and adds configurable lane width, bit order, output back-pressure, and a one-word holding buffer for gapless back-to-back frames. It sits between a word-wide producer and a narrow serial link or consumer.

## Interface
- WIDTH, 16: parallel word width in bits; must be ≥ 2.
- LANES, 1: bits emitted per beat; WIDTH % LANES == 0 is required, elaboration fails otherwise.
- MSB_FIRST, 0: 0 emits from the LSB end, 1 emits from the MSB end.
- Derived: BEATS = WIDTH/LANES, CW = max(1, $clog2(BEATS)).

Ports:
- clk, in, 1: single clock; everything is posedge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: producer has a word.
- in_ready, out, 1: block can accept a word.
- in_data, in, WIDTH: parallel word.
- out_valid, out, 1: out_data holds a valid beat.
- out_ready, in, 1: consumer accepts the beat.
- out_data, out, LANES: current beat.
- out_first, out, 1: the current beat is beat 0 of its word.
- out_last, out, 1: the current beat is beat BEATS-1 of its word.

## Operation
- State register is enum {IDLE, SHIFT}. Internal registers: sreg[WIDTH], cnt[CW], hbuf[WIDTH], hvalid.
- Accept (acc) = in_valid & in_ready. Beat (bt) = out_valid & out_ready.
- in_ready = ~hvalid & ~rst.
- out_valid = (state == SHIFT).
- out_data = MSB_FIRST ? sreg[WIDTH-1 -: LANES] : sreg[LANES-1:0].
- out_first = (cnt == 0). out_last = (cnt == BEATS-1). Both are qualified only when out_valid is high.
- IDLE:
  - On acc: sreg <= in_data, cnt <= 0, next state SHIFT.
  - hvalid is always 0 in IDLE.
- SHIFT, on a non-last bt:
  - sreg shifts by LANES toward the output end and zero-fills the vacated bits.
  - cnt++.
- SHIFT, on a last bt (out_last & bt):
  - If hvalid: sreg <= hbuf, hvalid <= 0, cnt <= 0, stay in SHIFT.
  - Else if acc: sreg <= in_data, cnt <= 0, stay in SHIFT (same-cycle pass-through).
  - Else: next state IDLE.
- SHIFT, on acc with no last bt: hbuf <= in_data, hvalid <= 1.
- No bt (out_ready low): sreg, cnt, out_data, out_first and out_last hold stable. An acc is still legal while hvalid is 0.
- Data order within a word is strictly preserved, and words are emitted in acceptance order.

## Timing
- Reset values: state IDLE, sreg 0, hbuf 0, hvalid 0, cnt 0. Resulting outputs: out_valid 0, out_data 0, out_first 1 (unqualified), out_last 0 (BEATS ≥ 2), in_ready 0 while rst is high, then 1.
- Latency: a word accepted at edge N produces its first beat (out_valid=1) in the cycle after edge N.
- Throughput with out_ready held high is one beat per cycle. Consecutive words run with zero idle cycles provided the next word arrives before the current word's last beat.
- in_ready falls the cycle after hbuf fills. It rises the cycle after hbuf transfers into sreg.
- Reset mid-frame: the current word and hbuf are discarded, and out_valid is 0 in the cycle following the reset edge.
- in_valid is ignored while in_ready is low. in_data is sampled only on acc.

## Structure
- Package piso_pkg holds:
  - typedef enum logic {IDLE, SHIFT} piso_state_t;
  - function piso_beats(width, lanes) for BEATS.
- Single module piso_stream. The holding register may be split out as sub-module piso_hold_reg (hbuf + hvalid, load/take strobes); this split is optional.
- Target size is 120–250 lines of RTL including parameter assertions.

## Test plan
- WIDTH=16, LANES=1, MSB_FIRST=0, in_data=0xA5C3, out_ready=1 -> 16 beats 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. out_first on beat 0, out_last on beat 15, out_valid=0 after.
- WIDTH=16, LANES=4, MSB_FIRST=1, in_data=0x1234 -> out_data 0x1,0x2,0x3,0x4 on consecutive cycles, out_last on the 4th beat.
- Back-to-back 0xFFFF then 0x0000, out_ready=1, LANES=1 -> 32 contiguous beats (16 ones then 16 zeros) with no out_valid gap. in_ready is 0 from the cycle after the second accept until the first word's last beat transfers.
- Back-pressure with 0xA5C3, out_ready=0 for 3 cycles starting at beat 5 -> out_data, cnt and out_first/out_last frozen for those 3 cycles. Resumes at beat 5 and finishes after 19 total valid cycles.
- rst=1 for one cycle at beat 7 with hbuf full -> next cycle out_valid=0, in_ready=1. Neither pending word is emitted afterward.
- in_valid held 0 after reset for 20 cycles -> out_valid stays 0 and in_ready stays 1.
